inner_loop_resolve_cpa: RTL and testbench
=========================================

Name: inner_loop_resolve_cpa

Overview:
Consumer of the redundant (r0, r1) pair produced by the inner-loop multiplier stage. It captures one pair on a valid/ready handshake and resolves r0 + r1 into a single binary word. The addition is done as a chunked carry-propagate pass, one CHUNK-bit slice per cycle with a registered carry. The result is presented to the downstream accumulator/reduction stage with a held valid/ready handshake.

Parameters:
W, 3152, width of r0/r1 (Size+radix+2 for Size=3072, radix=78)
CHUNK, 197, bits resolved per cycle; must be >= 1
NCHUNK, ceil(W/CHUNK) = 16, derived localparam; number of ADD cycles

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_valid  input  1  r0/r1 valid; driven from the inner loop's en_out
in_ready  output  1  block can accept a new pair
r0  input  W  redundant operand, low-half partials
r1  input  W  redundant operand, high-half partials (already shifted by radix)
sum  output  W+1  resolved r0 + r1; held while out_valid
out_valid  output  1  sum valid
out_ready  input  1  downstream accepts sum
busy  output  1  high in ADD or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, sum=0, out_valid=0, in_ready=1, busy=0, carry=0, chunk index=0, operand regs=0. Reset has priority over every other event, including mid-ADD and mid-DONE. A transaction in flight is discarded and no out_valid is produced for it.
- States:
  - IDLE: in_ready=1. in_valid=1 at an edge means accept. On accept: latch r0, r1 into operand regs, idx=0, carry=0, go to ADD.
  - ADD: in_ready=0. Each cycle compute {c, s} = r0q[idx] + r1q[idx] + carry on CHUNK-bit slices. Write s into sum[idx*CHUNK +: CHUNK] and set carry=c.
    - If idx != NCHUNK-1: idx++.
    - If idx == NCHUNK-1: sum[W] = final carry, go to DONE, out_valid=1.
  - DONE: out_valid=1, sum stable. out_valid & out_ready at an edge: out_valid=0, go to IDLE.
- Last slice when W % CHUNK != 0: operand bits above W-1 are zero-padded. The carry out of bit W-1 (not the padded top) lands in sum[W]. Bits beyond W are not stored.
- Latency: accept at edge E; out_valid rises after edge E+NCHUNK (16 cycles at defaults). Earliest next accept is the edge after the out handshake, giving a throughput of 1 per NCHUNK+2 cycles minimum.
- in_valid while not IDLE: ignored, no capture, r0/r1 not sampled. A level-held in_valid (the inner loop holds en_out) is accepted exactly once per IDLE visit; a still-high in_valid at the first IDLE cycle after DONE is accepted again.
- out_ready while out_valid=0: no effect. out_ready held high: DONE lasts exactly 1 cycle.
- sum bits are written progressively during ADD. Downstream must qualify with out_valid only.
- Slice width arithmetic is CHUNK+1 bits; there is no other carry chain longer than CHUNK+1.

Optional Feature:
RESOLVE_ZERO_FLAG_EN
- Defined: adds output port sum_zero (1 bit), reset 0.
  - Implemented as an OR-accumulate over each written slice plus the final carry.
  - sum_zero=1 in DONE iff sum == 0; cleared on accept.
  - No extra latency.
- Undefined: port and accumulate logic absent; all other behaviour identical.

Test Plan:
- Reset then r0=5, r1=7, in_valid pulse -> in_ready drops next cycle; out_valid after 16 edges; sum=12; with out_ready=1, out_valid drops 1 cycle later and in_ready=1.
- r0=all ones (W bits), r1=1 -> carry ripples through all 16 slices; sum = 2^W (only sum[W]=1); sum_zero=0 with macro.
- r0=0, r1=0 with RESOLVE_ZERO_FLAG_EN -> sum=0, sum_zero=1 in DONE.
- out_ready=0 for 10 cycles in DONE -> out_valid and sum held stable; second in_valid pulses during ADD/DONE ignored (sum unchanged, single accept).
- in_valid held high continuously with changing r0/r1, out_ready=1 -> one accept per 18-cycle period; each sum matches the r0+r1 sampled at its own accept edge.
- rst_n=0 at ADD cycle 7 for one cycle -> next edge: IDLE, out_valid=0, sum=0; subsequent transaction 3+4 -> sum=7.

Source files
------------

// File: rtl/inner_loop_resolve_cpa.sv
// inner_loop_resolve_cpa
// Resolves the redundant (r0, r1) pair from the inner-loop multiplier into a
// single binary word. It adds one CHUNK-bit slice per cycle and keeps the
// carry between slices in a register.
// Optional build macro: RESOLVE_ZERO_FLAG_EN adds the sum_zero output.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | in_ready=1, waiting for in_valid; operands latched on accept
// S_ADD  | one slice per cycle, idx 0..NCHUNK-1, carry registered
// S_DONE | out_valid=1, sum held until out_ready
module inner_loop_resolve_cpa #(
  parameter int W     = 3152,
  parameter int CHUNK = 197
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] r0,
  input  logic [W-1:0] r1,
  output logic [W:0]   sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
`ifdef RESOLVE_ZERO_FLAG_EN
  ,
  output logic         sum_zero
`endif
);

  localparam int NCHUNK   = (W + CHUNK - 1) / CHUNK;
  localparam int WP       = NCHUNK * CHUNK;
  // Number of real operand bits in the top slice. The carry out of bit W-1
  // sits directly above them, at this position in the slice result.
  localparam int LASTBITS = W - (NCHUNK - 1) * CHUNK;
  localparam int IW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  r0_q;
  logic [W-1:0]  r1_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [W:0]    sum_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          busy_q;

  logic [WP-1:0] r0_ext;
  logic [WP-1:0] r1_ext;
  logic [WP-1:0] sum_d;
  logic [CHUNK:0] slice;

  // Slice adder: zero-pads the operands to a whole number of slices and
  // merges the current slice result into the running sum.
  always_comb begin
    r0_ext = WP'(r0_q);
    r1_ext = WP'(r1_q);
    slice  = {1'b0, r0_ext[int'(idx_q)*CHUNK +: CHUNK]}
           + {1'b0, r1_ext[int'(idx_q)*CHUNK +: CHUNK]}
           + (CHUNK+1)'(carry_q);
    sum_d  = WP'(sum_q[W-1:0]);
    sum_d[int'(idx_q)*CHUNK +: CHUNK] = slice[CHUNK-1:0];
  end

  // Control FSM with registered handshake outputs. The sum register is written one slice at a time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      r0_q        <= '0;
      r1_q        <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            r0_q       <= r0;
            r1_q       <= r1;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_ADD;
          end
        end
        S_ADD: begin
          sum_q[W-1:0] <= sum_d[W-1:0];
          carry_q      <= slice[CHUNK];
          if (idx_q == IDX_LAST) begin
            sum_q[W]    <= slice[LASTBITS];
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;

`ifdef RESOLVE_ZERO_FLAG_EN
  logic nz_q;
  logic sum_zero_q;

  // OR-accumulate over every slice result. A carry out of any slice implies a
  // nonzero total, so ORing the whole slice, including its carry bit, is safe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nz_q       <= 1'b0;
      sum_zero_q <= 1'b0;
    end else if (state_q == S_IDLE && in_valid) begin
      nz_q       <= 1'b0;
      sum_zero_q <= 1'b0;
    end else if (state_q == S_ADD) begin
      nz_q <= nz_q | (|slice);
      if (idx_q == IDX_LAST) sum_zero_q <= ~(nz_q | (|slice));
    end
  end

  assign sum_zero = sum_zero_q;
`endif

endmodule

// File: tb/tb_inner_loop_resolve_cpa.sv
// Testbench for inner_loop_resolve_cpa: the driver pushes r0+r1 into a
// scoreboard queue, and a negedge monitor pops it and compares when out_valid rises.
module tb_inner_loop_resolve_cpa;

  localparam int W      = 3152;
  localparam int CHUNK  = 197;
  localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] r0 = '0;
  logic [W-1:0] r1 = '0;
  logic [W:0]   sum;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy;
`ifdef RESOLVE_ZERO_FLAG_EN
  logic         sum_zero;
`endif

  inner_loop_resolve_cpa dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r0        (r0),
    .r1        (r1),
    .sum       (sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef RESOLVE_ZERO_FLAG_EN
    ,
    .sum_zero  (sum_zero)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];
  int         acc_q[$];

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got lo64=%h top=%b, expected lo64=%h top=%b (%0d bits differ)",
               name, act[63:0], act[W], expv[63:0], expv[W], $countones(act ^ expv));
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = {v[W-33:0], 32'($urandom())};
    return v;
  endfunction

  // Monitor: pops one expected result each time out_valid rises. While
  // out_valid stays high it also checks that sum holds its value.
  logic       prev_ov = 1'b0;
  logic [W:0] held_sum;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [W:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("sum", sum, e);
          check("latency", (W+1)'(cyc - a), (W+1)'(NCHUNK));
`ifdef RESOLVE_ZERO_FLAG_EN
          check("sum_zero", (W+1)'(sum_zero), (W+1)'(e == '0));
`endif
        end
        held_sum = sum;
      end else if (out_valid) begin
        check("sum_hold", sum, held_sum);
      end
      prev_ov = out_valid;
    end
  end

  // Call at a negedge. Waits for in_ready, then presents a one-cycle pulse.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
    end else begin
      r0 = a;
      r1 = b;
      in_valid = 1'b1;
      exp_q.push_back({1'b0, a} + {1'b0, b});
      acc_q.push_back(cyc + 1);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 600) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    out_ready = 1'b1;
    if (exp_q.size() != 0 || !in_ready) check("drain_timeout", 0, 1);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  initial begin
    logic [W-1:0] ones;
    int n_acc;
    int last_acc;
    ones = '1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_in_ready", (W+1)'(in_ready), 1);
    check("reset_out_valid", (W+1)'(out_valid), 0);
    check("reset_busy", (W+1)'(busy), 0);
    check("reset_sum", sum, 0);

    // 5 + 7 with out_ready high
    out_ready = 1'b1;
    send(W'(5), W'(7));
    check("in_ready_drop", (W+1)'(in_ready), 0);
    check("busy_add", (W+1)'(busy), 1);
    wait_out_valid();
    @(negedge clk);
    check("out_valid_drop", (W+1)'(out_valid), 0);
    check("in_ready_back", (W+1)'(in_ready), 1);
    check("busy_idle", (W+1)'(busy), 0);
    drain(0);

    // full ripple and all-zero operands
    send(ones, W'(1));
    drain(0);
    send('0, '0);
    drain(0);

    // backpressure for 10 cycles while extra in_valid pulses are ignored
    out_ready = 1'b0;
    send(rnd_w(), rnd_w());
    for (int i = 0; i < 4; i++) begin
      r0 = rnd_w();
      r1 = rnd_w();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
    end
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      r0 = rnd_w();
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("held_out_valid", (W+1)'(out_valid), 1);
    out_ready = 1'b1;
    drain(0);

    // level-held in_valid with fresh operands every cycle
    n_acc = 0;
    last_acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 91; i++) begin
      r0 = rnd_w();
      r1 = rnd_w();
      if (in_ready) begin
        exp_q.push_back({1'b0, r0} + {1'b0, r1});
        acc_q.push_back(cyc + 1);
        if (n_acc > 0) check("period", (W+1)'(cyc + 1 - last_acc), (W+1)'(NCHUNK + 2));
        last_acc = cyc + 1;
        n_acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("held_accepts", (W+1)'(n_acc), 6);
    drain(0);

    // random operands with random backpressure
    for (int k = 0; k < 10; k++) begin
      case (k % 4)
        0: send(rnd_w(), rnd_w());
        1: send(ones, rnd_w());
        2: send(rnd_w() & {W/2{2'b01}}, rnd_w() | {W/2{2'b10}});
        default: send(ones, ones);
      endcase
      drain(1);
    end

    // reset during ADD cycle 7
    out_ready = 1'b1;
    send(rnd_w(), rnd_w());
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", (W+1)'(out_valid), 0);
    check("rst_sum", sum, 0);
    check("rst_in_ready", (W+1)'(in_ready), 1);
    check("rst_busy", (W+1)'(busy), 0);
    repeat (20) @(negedge clk);
    check("rst_no_output", (W+1)'(exp_q.size()), 0);
    send(W'(3), W'(4));
    drain(0);

    check("queue_empty", (W+1)'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
